// File: rtl/led_blink_pkg.sv
// Shared mode encoding for the LED blink bank and its channels.
package led_blink_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_ON    = 2'd1;
    localparam mode_t MODE_BLINK = 2'd2;
    localparam mode_t MODE_PULSE = 2'd3;

    function automatic logic is_counting(input mode_t m);
        return (m == MODE_BLINK) || (m == MODE_PULSE);
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: period counter, shadow/active config and registered LED/tick drive.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int               CNT_W      = 25,
    parameter logic [CNT_W-1:0] DEF_PERIOD = 25'd24_999_999,
    parameter mode_t            DEF_MODE   = MODE_BLINK
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] cfg_period,
    input  mode_t            cfg_mode,
    input  logic             sync,
    output logic             led,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] per_shd_q, per_shd_d;
    mode_t            mode_act_q, mode_act_d;
    mode_t            mode_shd_q, mode_shd_d;
    logic             pend_q, pend_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;

    logic             counting;
    logic             wrap;
    logic             load_pt;
    logic             do_load;
    logic [CNT_W-1:0] new_per;
    mode_t            new_mode;

    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        per_shd_d  = per_shd_q;
        mode_act_d = mode_act_q;
        mode_shd_d = mode_shd_q;
        pend_d     = pend_q;
        led_d      = led_q;
        tick_d     = tick_q;

        counting = is_counting(mode_act_q);
        wrap     = counting && (cnt_q >= per_act_q);
        // Static channels have no wrap, so any pending config lands on the next edge.
        load_pt  = sync || (counting ? wrap : pend_q);

        do_load  = 1'b0;
        new_per  = per_act_q;
        new_mode = mode_act_q;

        if (load_pt && wr_en) begin
            do_load  = 1'b1;
            new_per  = cfg_period;
            new_mode = cfg_mode;
            pend_d   = 1'b0;
        end else if (load_pt && pend_q) begin
            do_load  = 1'b1;
            new_per  = per_shd_q;
            new_mode = mode_shd_q;
            pend_d   = 1'b0;
        end else if (wr_en) begin
            per_shd_d  = cfg_period;
            mode_shd_d = cfg_mode;
            pend_d     = 1'b1;
        end

        if (do_load) begin
            per_act_d  = new_per;
            mode_act_d = new_mode;
            cnt_d      = '0;
            if (is_counting(new_mode)) begin
                led_d  = 1'b0;
                tick_d = wrap && !sync;
            end else begin
                led_d  = (new_mode == MODE_ON);
                tick_d = 1'b0;
            end
        end else if (!counting) begin
            cnt_d  = '0;
            tick_d = 1'b0;
            led_d  = (mode_act_q == MODE_ON);
        end else if (sync) begin
            cnt_d  = '0;
            led_d  = 1'b0;
            tick_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            led_d  = (mode_act_q == MODE_BLINK) ? !led_q : 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = 1'b0;
            led_d  = (mode_act_q == MODE_BLINK) ? led_q : 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q      <= '0;
            per_act_q  <= DEF_PERIOD;
            per_shd_q  <= DEF_PERIOD;
            mode_act_q <= DEF_MODE;
            mode_shd_q <= DEF_MODE;
            pend_q     <= 1'b0;
            led_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            per_shd_q  <= per_shd_d;
            mode_act_q <= mode_act_d;
            mode_shd_q <= mode_shd_d;
            pend_q     <= pend_d;
            led_q      <= led_d;
            tick_q     <= tick_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign pend = pend_q;

endmodule

// File: rtl/led_blink_bank.sv
// Bank of independent LED blink channels with shared config port and phase-sync strobe.
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter int               CH_NUM     = 4,
    parameter int               CNT_W      = 25,
    parameter logic [CNT_W-1:0] DEF_PERIOD = 25'd24_999_999,
    parameter mode_t            DEF_MODE   = MODE_BLINK
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [1:0]        cfg_mode,
    input  logic              sync_in,
    output logic [CH_NUM-1:0] led_out,
    output logic [CH_NUM-1:0] tick_out,
    output logic [CH_NUM-1:0] cfg_pend
);

    logic [CH_NUM-1:0] wr_en_vec;

    // Indices at or above CH_NUM match no channel, so such writes are dropped.
    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
            assign wr_en_vec[gi] = cfg_we && (cfg_ch == 4'(gi));

            led_blink_chan #(
                .CNT_W      (CNT_W),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_MODE   (DEF_MODE)
            ) u_chan (
                .sys_clk    (sys_clk),
                .sys_rst    (sys_rst),
                .wr_en      (wr_en_vec[gi]),
                .cfg_period (cfg_period),
                .cfg_mode   (cfg_mode),
                .sync       (sync_in),
                .led        (led_out[gi]),
                .tick       (tick_out[gi]),
                .pend       (cfg_pend[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_blink_bank.sv
// Scoreboard bench for led_blink_bank: expectations queued per edge, checked by a monitor.
module tb_led_blink_bank;
    import led_blink_pkg::*;

    localparam int CNT_W = 25;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_ch = 4'd0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [1:0]       cfg_mode = 2'd0;
    logic             sync_in = 1'b0;
    logic [3:0]       led_out, tick_out, cfg_pend;

    led_blink_bank #(
        .CH_NUM     (4),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (25'd4),
        .DEF_MODE   (MODE_BLINK)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .sync_in    (sync_in),
        .led_out    (led_out),
        .tick_out   (tick_out),
        .cfg_pend   (cfg_pend)
    );

    always #5 sys_clk = ~sys_clk;

    // Edge index since the last reset release.
    int edge_cnt;
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) edge_cnt <= 0;
        else         edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        int         at;
        int         sig;
        logic [3:0] val;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    string phase = "";

    localparam int S_LED  = 0;
    localparam int S_TICK = 1;
    localparam int S_PEND = 2;

    function automatic string sig_name(input int s);
        case (s)
            S_LED:   return "led_out";
            S_TICK:  return "tick_out";
            default: return "cfg_pend";
        endcase
    endfunction

    task automatic expect_at(input int at, input int sig, input logic [3:0] val);
        exp_t e;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        e.tag = phase;
        sb_q.push_back(e);
    endtask

    // Monitor: pops every expectation whose edge has been reached.
    initial begin
        exp_t       it;
        logic [3:0] act;
        forever begin
            @(negedge sys_clk);
            while (sb_q.size() > 0 && sb_q[0].at <= edge_cnt) begin
                it = sb_q.pop_front();
                case (it.sig)
                    S_LED:   act = led_out;
                    S_TICK:  act = tick_out;
                    default: act = cfg_pend;
                endcase
                checks++;
                if (it.at != edge_cnt) begin
                    errors++;
                    $display("FAIL %s %s edge %0d: expectation missed, now at edge %0d",
                             it.tag, sig_name(it.sig), it.at, edge_cnt);
                end else if (act !== it.val) begin
                    errors++;
                    $display("FAIL %s %s edge %0d: got %h expected %h",
                             it.tag, sig_name(it.sig), it.at, act, it.val);
                end else begin
                    $display("ok   %s %s edge %0d = %h", it.tag, sig_name(it.sig), it.at, act);
                end
            end
        end
    end

    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_cnt < n && guard < 1000) begin
            @(posedge sys_clk);
            #1;
            guard++;
        end
    endtask

    task automatic cfg_pulse(input int at, input logic [3:0] ch,
                             input logic [CNT_W-1:0] per, input logic [1:0] mode);
        wait_edge(at - 1);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = per;
        cfg_mode   = mode;
        wait_edge(at);
        cfg_we     = 1'b0;
    endtask

    task automatic drain_queue();
        for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge sys_clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never reached, first at edge %0d", sb_q.size(), sb_q[0].at);
            sb_q.delete();
        end
    endtask

    // Reset is raised mid-cycle; outputs must be 0 at the very next negedge, with no clock edge between.
    task automatic phase_reset(input string name);
        drain_queue();
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        phase   = name;
        expect_at(0, S_LED,  4'h0);
        expect_at(0, S_TICK, 4'h0);
        expect_at(0, S_PEND, 4'h0);
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
    endtask

    initial begin
        // Reset defaults: every channel blinks with P=4.
        phase_reset("defaults");
        expect_at(4,  S_TICK, 4'h0); expect_at(4,  S_LED, 4'h0);
        expect_at(5,  S_TICK, 4'hF); expect_at(5,  S_LED, 4'hF);
        expect_at(6,  S_TICK, 4'h0); expect_at(9,  S_LED, 4'hF);
        expect_at(10, S_TICK, 4'hF); expect_at(10, S_LED, 4'h0);
        expect_at(11, S_TICK, 4'h0);
        expect_at(15, S_TICK, 4'hF); expect_at(15, S_LED, 4'hF);
        wait_edge(15);

        // Deferred period change on ch1.
        phase_reset("deferred");
        expect_at(1,  S_PEND, 4'h0);
        expect_at(2,  S_PEND, 4'h2);
        expect_at(4,  S_PEND, 4'h2);
        expect_at(5,  S_PEND, 4'h0); expect_at(5,  S_TICK, 4'hF); expect_at(5, S_LED, 4'hD);
        expect_at(7,  S_TICK, 4'h0);
        expect_at(8,  S_TICK, 4'h2); expect_at(8,  S_LED, 4'hF);
        expect_at(10, S_TICK, 4'hD); expect_at(10, S_LED, 4'h2);
        expect_at(11, S_TICK, 4'h2); expect_at(11, S_LED, 4'h0);
        cfg_pulse(2, 4'd1, 25'd2, MODE_BLINK);
        wait_edge(11);

        // Mode changes on ch0: OFF deferred to wrap, then ON one edge later.
        phase_reset("modes");
        expect_at(9,  S_LED,  4'hF); expect_at(9,  S_PEND, 4'h1);
        expect_at(10, S_TICK, 4'hE); expect_at(10, S_LED,  4'h0); expect_at(10, S_PEND, 4'h0);
        expect_at(15, S_TICK, 4'hE); expect_at(15, S_LED,  4'hE);
        expect_at(16, S_LED,  4'hE); expect_at(16, S_PEND, 4'h1);
        expect_at(17, S_LED,  4'hF); expect_at(17, S_PEND, 4'h0); expect_at(17, S_TICK, 4'h0);
        expect_at(20, S_TICK, 4'hE); expect_at(20, S_LED,  4'h1);
        cfg_pulse(6, 4'd0, 25'd4, MODE_OFF);
        cfg_pulse(16, 4'd0, 25'd4, MODE_ON);
        wait_edge(20);

        // PULSE with P=0 on ch2.
        phase_reset("pulse0");
        expect_at(1,  S_PEND, 4'h4);
        expect_at(4,  S_PEND, 4'h4);
        expect_at(5,  S_PEND, 4'h0); expect_at(5,  S_TICK, 4'hF); expect_at(5, S_LED, 4'hB);
        expect_at(6,  S_TICK, 4'h4); expect_at(6,  S_LED,  4'hF);
        expect_at(8,  S_TICK, 4'h4); expect_at(8,  S_LED,  4'hF);
        expect_at(10, S_TICK, 4'hF); expect_at(10, S_LED,  4'h4);
        expect_at(11, S_TICK, 4'h4); expect_at(11, S_LED,  4'h4);
        cfg_pulse(1, 4'd2, 25'd0, MODE_PULSE);
        wait_edge(11);

        // Phase sync: stagger channels to cnt 0/1/2/3, then sync_in at edge 12.
        phase_reset("sync");
        expect_at(4,  S_PEND, 4'hF);
        expect_at(5,  S_PEND, 4'h0); expect_at(5,  S_TICK, 4'h0); expect_at(5, S_LED, 4'h0);
        expect_at(6,  S_PEND, 4'h8);
        expect_at(10, S_PEND, 4'h0); expect_at(10, S_LED,  4'h0);
        expect_at(11, S_TICK, 4'h0);
        expect_at(12, S_TICK, 4'h0); expect_at(12, S_LED,  4'h0);
        expect_at(16, S_TICK, 4'h0);
        expect_at(17, S_TICK, 4'hF); expect_at(17, S_LED,  4'hF);
        expect_at(18, S_TICK, 4'h0);
        for (int c = 0; c < 4; c++) cfg_pulse(c + 1, 4'(c), 25'd4, MODE_OFF);
        for (int c = 0; c < 4; c++) cfg_pulse(c + 6, 4'(3 - c), 25'd4, MODE_BLINK);
        wait_edge(11);
        sync_in = 1'b1;
        wait_edge(12);
        sync_in = 1'b0;
        wait_edge(18);

        // Invalid channel index is ignored; the final reset lands mid-count with LEDs lit.
        phase_reset("badidx");
        expect_at(7,  S_PEND, 4'h0);
        expect_at(10, S_TICK, 4'hF); expect_at(10, S_LED, 4'h0);
        expect_at(15, S_TICK, 4'hF); expect_at(15, S_LED, 4'hF);
        cfg_pulse(7, 4'd5, 25'd1, MODE_OFF);
        wait_edge(16);
        phase_reset("async_rst");
        drain_queue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_blink_bank.md
# led_blink_bank

Multi-channel, parametrised successor to the single-LED blink counter. Each of `CH_NUM` channels has its own period counter, runtime-programmable period, and mode: off, on, blink, or pulse. Config writes are shadowed and take effect only at a period boundary, so LEDs never glitch. A shared `sync_in` phase-aligns all channels. The block sits between board-level control logic and the LED pins.

## Interface
- `CH_NUM`, 4: number of channels, 1..16.
- `CNT_W`, 25: counter and period width.
- `DEF_PERIOD`, 25'd24_999_999: reset period for every channel. 1 Hz blink at 50 MHz.
- `DEF_MODE`, 2'd2: reset mode for every channel (BLINK).

- `sys_clk` input 1: system clock; all logic is on its rising edge.
- `sys_rst` input 1: asynchronous, active-high reset.
- `cfg_we` input 1: one-cycle config write strobe.
- `cfg_ch` input 4: target channel index; values ≥ `CH_NUM` are ignored.
- `cfg_period` input `CNT_W`: new period P; the channel wraps every P+1 cycles.
- `cfg_mode` input 2: 0 OFF, 1 ON, 2 BLINK, 3 PULSE.
- `sync_in` input 1: one-cycle strobe that restarts all counters.
- `led_out` output `CH_NUM`: LED drive, registered.
- `tick_out` output `CH_NUM`: one-cycle wrap pulse per channel, registered.
- `cfg_pend` output `CH_NUM`: high while the channel holds an unapplied shadow config.

## Operation
**Per-channel registers:** `cnt`, `per_act`, `mode_act`, `per_shd`, `mode_shd`, `pend`, `led`, `tick`.

**Reset values (all outputs 0):**
- `cnt` = 0, `per_act` = `DEF_PERIOD`, `mode_act` = `DEF_MODE`
- `pend` = 0, `led_out` = 0, `tick_out` = 0

**Config write** (`cfg_we`, `cfg_ch` < `CH_NUM`):
- The shadow registers are updated and `pend` is set to 1.
- A second write before load overwrites the shadow; last write wins.

**Counting modes (BLINK, PULSE):**
- `cnt` increments each cycle.
- When `cnt >= per_act` (wrap): `cnt` ← 0 and `tick` ← 1; otherwise `tick` ← 0.
- BLINK: `led` toggles on each wrap.
- PULSE: `led` ← `tick` next value, i.e. high for one cycle per wrap.

**Static modes (OFF, ON):**
- `cnt` is held at 0 and `tick` is 0.
- `led` is 0 in OFF and 1 in ON.

**Load** (`pend` = 1, i.e. shadow → active, then `pend` ← 0):
- In counting modes, load occurs on the wrap edge.
- In static modes, load occurs on the next edge.
- On load, `cnt` ← 0.
- Entering BLINK or PULSE forces `led` ← 0; the wrap tick of that edge is still emitted.
- Entering OFF or ON sets `led` per the new mode and `tick` ← 0.

**Write coinciding with wrap or load edge:**
- The incoming `cfg_*` data is loaded directly, bypassing the shadow.
- `pend` ends at 0.

**`sync_in`:**
- All counting channels: `cnt` ← 0, `led` ← 0, `tick` ← 0.
- Pending shadows are loaded in the same edge.
- Priority: `sync_in` > wrap > count.

**P = 0:**
- A wrap occurs every cycle.
- BLINK toggles every cycle; PULSE holds `tick_out` = `led_out` = 1 continuously.

**Invariant:** `cnt` ≤ `per_act` at all times.

## Timing
- Edge 1 is the first rising edge after `sys_rst` falls.
- With period P, `cnt` = P after edge P.
- At edge P+1: `tick_out` rises for exactly one cycle and `led` (BLINK) toggles. Subsequent wraps follow every P+1 edges.
- Config-write to active latency: at most P+1 cycles in counting modes; exactly 1 cycle in static modes.
- `cfg_pend` rises on the edge after the write and falls on the load edge.
- `sync_in` sampled at edge k: the next tick appears at edge k+P+1.
- `sys_rst` assertion clears every output immediately, without a clock edge. Any in-flight config is lost.

## Structure
- **Package `led_blink_pkg`:** mode localparams `MODE_OFF`/`MODE_ON`/`MODE_BLINK`/`MODE_PULSE`, plus the mode width (2).
- **Sub-module `led_blink_chan`:** one channel, containing the counter, shadow/active registers, and LED/tick logic. It is instantiated `CH_NUM` times via generate.
- **Top level:** `cfg_ch` decode into per-channel write enables, and `sync_in` fan-out.

## Test plan
- **Reset defaults:** `CH_NUM`=4, `DEF_PERIOD`=4, BLINK. Expect `tick_out` = 4'hF at edges 5, 10, 15, and `led_out` toggling 0→F→0.
- **Deferred period change:** write ch1 P=2 at ch1 `cnt`=1. Expect `cfg_pend[1]`=1 until edge 5, then ch1 ticks at edges 8, 11; other channels unchanged.
- **Mode changes:** ch0 BLINK with `led`=1, write OFF. Expect `led_out[0]`=1 until the next wrap, then 0 with no further ticks. Then write ON: `led_out[0]`=1 one edge later.
- **PULSE with P=0:** write ch2 PULSE, P=0. Expect `tick_out[2]` = `led_out[2]` = 1 every cycle after the load.
- **Phase sync:** ch0..3 at `cnt` 0/1/2/3, pulse `sync_in` at edge k. Expect all `cnt`=0, `led_out`=0, no tick at edge k, all ticks at edge k+5.
- **Async reset and invalid index:** assert `sys_rst` mid-count. Expect outputs 0 before any edge. Write with `cfg_ch`=5: expect no `cfg_pend` bit set and behaviour unchanged.
